// File: rtl/segasys_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | segasys_pkg                                                                |
// | Shared definitions for the Sega system-board sound command path: hand-off |
// | FSM state encoding, default I/O port addresses (also used by the I/O port  |
// | decoder) and the status-byte count saturation helper.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package segasys_pkg;

  // Mailbox hand-off FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } snd_state_e;

  // Default Z80 I/O addresses (CPUAD[7:0])
  localparam logic [7:0] c_SND_PORT_A    = 8'h14;
  localparam logic [7:0] c_SND_PORT_B    = 8'h18;
  localparam logic [7:0] c_SND_STAT_ADDR = 8'h1C;

  // The status byte only has a 4-bit count field; deeper FIFOs report 15
  function automatic logic [3:0] sat_cnt4(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/segasys_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | segasys_sync_fifo                                                          |
// | Single-clock FIFO, depth 2**AW, inferred register array, unregistered     |
// | read data (rdata_o always shows the head entry).                           |
// | Ports: CLK40M/RESET (async, active-high) clock and reset;                  |
// |        push_i/wdata_i write; pop_i read; rdata_o head entry;               |
// |        full_o/empty_o flags; count_o occupancy 0..2**AW.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module segasys_sync_fifo
  import segasys_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          CLK40M,
  input  logic          RESET,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A simultaneous pop frees the head slot, so a push while full still lands
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; the pointers define what is valid
  always_ff @(posedge CLK40M) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/segasys_snd_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | segasys_snd_mailbox                                                        |
// | Main-CPU to sound-CPU command mailbox. Z80 I/O writes to PORT_A/PORT_B are |
// | queued in a FIFO and handed to the sound side one at a time with a        |
// | SNDRQ/SND_ACK handshake (or a 1-cycle SNDRQ strobe when PULSE_MODE=1),     |
// | with HOLDOFF low cycles between commands. A status byte is readable at    |
// | STAT_ADDR.                                                                 |
// | Ports: CLK40M/RESET (async, active-high); CPUAD/CPUDO/CPU_IORQ/CPU_WR/     |
// |        CPU_RD Z80 bus; SND_ACK sound-side consume; SNDRQ/SNDNO command     |
// |        out; STAT_CS status select (combinational); STAT_DO status byte    |
// |        {cnt[3:0], 0, ovf, full, empty}.                                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module segasys_snd_mailbox
  import segasys_pkg::*;
#(
  parameter int         AW         = 3,
  parameter int         DW         = 8,
  parameter logic [7:0] PORT_A     = c_SND_PORT_A,
  parameter logic [7:0] PORT_B     = c_SND_PORT_B,
  parameter logic [7:0] STAT_ADDR  = c_SND_STAT_ADDR,
  parameter int         PULSE_MODE = 0,
  parameter int         HOLDOFF    = 4
) (
  input  logic          CLK40M,
  input  logic          RESET,
  input  logic [7:0]    CPUAD,
  input  logic [DW-1:0] CPUDO,
  input  logic          CPU_IORQ,
  input  logic          CPU_WR,
  input  logic          CPU_RD,
  input  logic          SND_ACK,
  output logic          SNDRQ,
  output logic [DW-1:0] SNDNO,
  output logic          STAT_CS,
  output logic [7:0]    STAT_DO
);

  // The IDLE cycle that pops the next command is itself the last low cycle,
  // so GAP only has to cover HOLDOFF-1 cycles.
  localparam int            HCW         = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0] c_HOLD_LAST = HCW'((HOLDOFF > 2) ? (HOLDOFF - 2) : 0);

  snd_state_e     state_q, state_d;
  logic           sndrq_q, sndrq_d;
  logic [DW-1:0]  sndno_q, sndno_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           ovf_q, ovf_d;
  logic           wr_hit_q;
  logic           rd_sel_q;

  logic           wr_hit;
  logic           push;
  logic           pop;
  logic           rd_sel;
  logic           rd_fall;
  logic [DW-1:0]  head;
  logic           full;
  logic           empty;
  logic [AW:0]    count;

  // Write strobe is held for several clocks; push only on its rising edge
  assign wr_hit  = CPU_IORQ && CPU_WR && ((CPUAD == PORT_A) || (CPUAD == PORT_B));
  assign push    = wr_hit && !wr_hit_q;

  assign STAT_CS = CPU_IORQ && (CPUAD == STAT_ADDR);
  assign rd_sel  = STAT_CS && CPU_RD;
  assign rd_fall = rd_sel_q && !rd_sel;

  segasys_sync_fifo #(
    .AW (AW),
    .DW (DW)
  ) u_fifo (
    .CLK40M  (CLK40M),
    .RESET   (RESET),
    .push_i  (push),
    .wdata_i (CPUDO),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Overflow only when the push is actually dropped; set beats the read clear
  always_comb begin
    ovf_d = ovf_q;
    if (rd_fall)                ovf_d = 1'b0;
    if (push && full && !pop)   ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    sndrq_d = sndrq_q;
    sndno_d = sndno_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sndno_d = head;
          sndrq_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if ((PULSE_MODE != 0) || SND_ACK) begin
          sndrq_d = 1'b0;
          hold_d  = '0;
          state_d = (HOLDOFF <= 1) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (hold_q == c_HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sndrq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      sndrq_q  <= 1'b0;
      sndno_q  <= '0;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
      wr_hit_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sndrq_q  <= sndrq_d;
      sndno_q  <= sndno_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      wr_hit_q <= wr_hit;
      rd_sel_q <= rd_sel;
    end
  end

  assign SNDRQ   = sndrq_q;
  assign SNDNO   = sndno_q;
  assign STAT_DO = {sat_cnt4(32'(count)), 1'b0, ovf_q, full, empty};

endmodule
`default_nettype wire

// File: tb/tb_segasys_snd_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_segasys_snd_mailbox                                                     |
// | Scoreboard bench: stimulus queues expected commands, a monitor pops and   |
// | compares them on every SNDRQ rise. u_dut: AW=2 handshake mode;            |
// | u_pls: AW=3 PULSE_MODE=1. Both share the CPU bus; one is held in reset    |
// | while the other is exercised.                                              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_segasys_snd_mailbox;

  localparam int HOLDOFF = 4;

  typedef struct {
    logic [7:0] data;
    bit         chk_gap;
  } exp_t;

  logic       CLK40M;
  logic       RESET;
  logic       RESET_P;
  logic [7:0] CPUAD;
  logic [7:0] CPUDO;
  logic       CPU_IORQ;
  logic       CPU_WR;
  logic       CPU_RD;
  logic       SND_ACK;
  logic       p_SND_ACK;

  logic       m_SNDRQ, p_SNDRQ;
  logic [7:0] m_SNDNO, p_SNDNO;
  logic       m_STAT_CS, p_STAT_CS;
  logic [7:0] m_STAT_DO, p_STAT_DO;

  exp_t exp_m[$];
  exp_t exp_p[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ack_auto = 0;

  segasys_snd_mailbox #(.AW(2), .DW(8), .PULSE_MODE(0), .HOLDOFF(HOLDOFF)) u_dut (
    .CLK40M(CLK40M), .RESET(RESET), .CPUAD(CPUAD), .CPUDO(CPUDO),
    .CPU_IORQ(CPU_IORQ), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .SND_ACK(SND_ACK),
    .SNDRQ(m_SNDRQ), .SNDNO(m_SNDNO), .STAT_CS(m_STAT_CS), .STAT_DO(m_STAT_DO)
  );

  segasys_snd_mailbox #(.AW(3), .DW(8), .PULSE_MODE(1), .HOLDOFF(HOLDOFF)) u_pls (
    .CLK40M(CLK40M), .RESET(RESET_P), .CPUAD(CPUAD), .CPUDO(CPUDO),
    .CPU_IORQ(CPU_IORQ), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .SND_ACK(p_SND_ACK),
    .SNDRQ(p_SNDRQ), .SNDNO(p_SNDNO), .STAT_CS(p_STAT_CS), .STAT_DO(p_STAT_DO)
  );

  initial CLK40M = 1'b0;
  always #5 CLK40M = ~CLK40M;

  assign p_SND_ACK = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d, input int hold);
    CPUAD = a; CPUDO = d; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
    repeat (hold) @(negedge CLK40M);
    CPU_IORQ = 1'b0; CPU_WR = 1'b0;
    @(negedge CLK40M);
  endtask

  task automatic stat_rd(input string nm, input logic [7:0] req);
    CPUAD = 8'h1C; CPU_IORQ = 1'b1; CPU_RD = 1'b1;
    @(negedge CLK40M);
    chk({nm, " STAT_CS"}, m_STAT_CS, 1);
    chk({nm, " STAT_DO"}, m_STAT_DO, req);
    CPU_IORQ = 1'b0; CPU_RD = 1'b0;
    @(negedge CLK40M);
  endtask

  // Sound-side responder: ACK one cycle after each SNDRQ rise
  initial begin : ack_responder
    bit pend = 0;
    bit rq_prev = 0;
    SND_ACK = 1'b0;
    forever begin
      @(negedge CLK40M);
      SND_ACK = 1'b0;
      if (ack_auto && m_SNDRQ && !rq_prev) pend = 1;
      else if (pend) begin
        SND_ACK = 1'b1;
        pend = 0;
      end
      rq_prev = m_SNDRQ;
    end
  end

  // Monitor: sample 1 time unit after each rising edge
  initial begin : monitor
    exp_t e;
    bit   m_prev = 0, p_prev = 0;
    int   m_low = 0, p_low = 0, p_high = 0;
    forever begin
      @(posedge CLK40M);
      #1;
      if (RESET) begin
        m_prev = 0; m_low = 0;
      end else begin
        if (m_SNDRQ && !m_prev) begin
          if (exp_m.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_main: unexpected SNDRQ with SNDNO=%02h, required no request", m_SNDNO);
          end else begin
            e = exp_m.pop_front();
            chk("sb_main SNDNO", m_SNDNO, e.data);
            if (e.chk_gap) chk("sb_main low gap", m_low, HOLDOFF);
          end
          m_low = 0;
        end else if (!m_SNDRQ) m_low++;
        m_prev = m_SNDRQ;
      end
      if (RESET_P) begin
        p_prev = 0; p_low = 0; p_high = 0;
      end else begin
        if (p_SNDRQ && !p_prev) begin
          if (exp_p.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_pulse: unexpected SNDRQ with SNDNO=%02h, required no request", p_SNDNO);
          end else begin
            e = exp_p.pop_front();
            chk("sb_pulse SNDNO", p_SNDNO, e.data);
            if (e.chk_gap) chk("sb_pulse low gap", p_low, HOLDOFF);
          end
          p_low = 0; p_high = 1;
        end else if (p_SNDRQ) begin
          p_high++;
        end else begin
          if (p_prev) chk("sb_pulse strobe width", p_high, 1);
          p_low++;
        end
        p_prev = p_SNDRQ;
      end
    end
  end

  initial begin : stimulus
    RESET = 1'b1; RESET_P = 1'b1;
    CPUAD = 8'h00; CPUDO = 8'h00; CPU_IORQ = 1'b0; CPU_WR = 1'b0; CPU_RD = 1'b0;
    repeat (3) @(negedge CLK40M);
    RESET = 1'b0;
    @(negedge CLK40M);

    // Reset state
    chk("reset SNDRQ", m_SNDRQ, 0);
    chk("reset SNDNO", m_SNDNO, 8'h00);
    stat_rd("reset status", 8'h01);

    // 1: single write, strobe held 8 clocks; push-to-SNDRQ = 2 cycles
    ack_auto = 1;
    exp_m.push_back('{8'h5A, 1'b0});
    CPUAD = 8'h14; CPUDO = 8'h5A; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
    @(negedge CLK40M);
    chk("t1 SNDRQ after 1 cycle", m_SNDRQ, 0);
    @(negedge CLK40M);
    chk("t1 SNDRQ after 2 cycles", m_SNDRQ, 1);
    chk("t1 SNDNO", m_SNDNO, 8'h5A);
    repeat (6) @(negedge CLK40M);
    CPU_IORQ = 1'b0; CPU_WR = 1'b0;
    @(negedge CLK40M);
    stat_rd("t1 status", 8'h01);
    repeat (15) @(negedge CLK40M);
    chk("t1 SNDRQ idle", m_SNDRQ, 0);
    chk("t1 SNDNO held", m_SNDNO, 8'h5A);

    // 2: three back-to-back commands, HOLDOFF low cycles between them
    exp_m.push_back('{8'h01, 1'b0});
    exp_m.push_back('{8'h02, 1'b1});
    exp_m.push_back('{8'h03, 1'b1});
    cpu_wr(8'h14, 8'h01, 2);
    cpu_wr(8'h14, 8'h02, 2);
    cpu_wr(8'h14, 8'h03, 2);
    repeat (25) @(negedge CLK40M);
    chk("t2 SNDNO held", m_SNDNO, 8'h03);

    // 3: no ACK, six writes via alias port into a depth-4 FIFO
    ack_auto = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_m.push_back('{8'h10 + 8'(i), 1'b0});
      cpu_wr(8'h18, 8'h10 + 8'(i), 2);
    end
    chk("t3 SNDRQ held", m_SNDRQ, 1);
    chk("t3 SNDNO", m_SNDNO, 8'h10);
    stat_rd("t3 status full/ovf", 8'h46);

    // 4: ovf cleared by previous read; overflow in the clear cycle wins
    CPUAD = 8'h1C; CPU_IORQ = 1'b1; CPU_RD = 1'b1;
    @(negedge CLK40M);
    chk("t4 STAT_CS", m_STAT_CS, 1);
    chk("t4 status ovf cleared", m_STAT_DO, 8'h42);
    CPUAD = 8'h18; CPUDO = 8'h16; CPU_RD = 1'b0; CPU_WR = 1'b1;
    @(negedge CLK40M);
    chk("t4 STAT_CS on write port", m_STAT_CS, 0);
    @(negedge CLK40M);
    CPU_IORQ = 1'b0; CPU_WR = 1'b0;
    @(negedge CLK40M);
    stat_rd("t4 status set wins", 8'h46);

    // 5: reset mid-transfer with 3 queued
    RESET = 1'b1; exp_m.delete();
    @(negedge CLK40M);
    RESET = 1'b0;
    @(negedge CLK40M);
    for (int i = 0; i < 4; i++) begin
      exp_m.push_back('{8'h20 + 8'(i), 1'b0});
      cpu_wr(8'h14, 8'h20 + 8'(i), 2);
    end
    stat_rd("t5 status 3 queued", 8'h30);
    chk("t5 SNDRQ before reset", m_SNDRQ, 1);
    #2;
    RESET = 1'b1; exp_m.delete();
    #1;
    chk("t5 SNDRQ async reset", m_SNDRQ, 0);
    chk("t5 SNDNO async reset", m_SNDNO, 8'h00);
    @(negedge CLK40M);
    stat_rd("t5 status in reset", 8'h01);
    RESET = 1'b0; ack_auto = 1;
    repeat (15) @(negedge CLK40M);
    chk("t5 no stale SNDRQ", m_SNDRQ, 0);
    exp_m.push_back('{8'h77, 1'b0});
    cpu_wr(8'h14, 8'h77, 2);
    repeat (12) @(negedge CLK40M);

    // 6: pulse mode, three strobes spaced 1+HOLDOFF apart
    RESET = 1'b1; RESET_P = 1'b0; ack_auto = 0;
    @(negedge CLK40M);
    exp_p.push_back('{8'h31, 1'b0});
    exp_p.push_back('{8'h32, 1'b1});
    exp_p.push_back('{8'h33, 1'b1});
    cpu_wr(8'h14, 8'h31, 2);
    cpu_wr(8'h14, 8'h32, 2);
    cpu_wr(8'h14, 8'h33, 2);
    repeat (30) @(negedge CLK40M);
    chk("t6 SNDRQ idle", p_SNDRQ, 0);
    chk("t6 SNDNO held", p_SNDNO, 8'h33);

    chk("main scoreboard drained", exp_m.size(), 0);
    chk("pulse scoreboard drained", exp_p.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
